hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, multi-cycle op stalls and branch flushes.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int RA_W   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_mem_read,
  input  logic            id_mc_op,
  input  logic            branch_taken,
  output logic            pc_write,
  output logic            if_id_write,
  output logic            if_id_flush,
  output logic            id_ex_bubble,
  output logic [1:0]      state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]     perf_stall_cnt,
  output logic [15:0]     perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MC_WAIT = 2'd1,
    RELEASE = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  localparam logic [3:0] MC_INIT = 4'(MC_LAT - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       lu;

  assign lu = ex_mem_read && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (branch_taken) begin
      state_next = RUN;
      cnt_next   = 4'd0;
    end else begin
      case (state)
        RUN: begin
          if (!lu && id_mc_op) begin
            state_next = MC_WAIT;
            cnt_next   = MC_INIT;
          end
        end
        MC_WAIT: begin
          cnt_next = cnt - 4'd1;
          // A zero count can only come from corruption; release rather than wrap.
          if (cnt <= 4'd1) state_next = RELEASE;
        end
        RELEASE: state_next = RUN;
        default: begin
          state_next = RUN;
          cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (lu || id_mc_op) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        RELEASE: begin
          if (lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        default: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 16'd0;
      perf_flush_cnt <= 16'd0;
    end else begin
      if (!pc_write && (perf_stall_cnt != 16'hFFFF)) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (if_id_flush && (perf_flush_cnt != 16'hFFFF)) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: expected control vectors are queued per step and popped for checking.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_mem_read, id_mc_op, branch_taken;
  logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_EN
  logic [15:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int testCount = 0;
  int failCount = 0;

  typedef struct {
    string      tag;
    logic [5:0] vec;
  } exp_t;
  exp_t expQ[$];

  // Expected vector layout: {pc_write, if_id_write, if_id_flush, id_ex_bubble, state_o}
  localparam logic [5:0] RUN_OUT = 6'b1100_00;
  localparam logic [5:0] STALL0  = 6'b0001_00;
  localparam logic [5:0] WAIT_ST = 6'b0001_01;
  localparam logic [5:0] REL_OUT = 6'b1100_10;
  localparam logic [5:0] RST_OUT = 6'b0011_00;

  hazard_ctrl #(.MC_LAT(4), .RA_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .id_mc_op     (id_mc_op),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .state_o      (state_o)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic mr, input logic mc,
                               input logic br, input logic [5:0] expVec);
    exp_t e;
    id_rs1       = rs1;
    id_rs2       = rs2;
    ex_rd        = rd;
    ex_mem_read  = mr;
    id_mc_op     = mc;
    branch_taken = br;
    e.tag = tag;
    e.vec = expVec;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [5:0] obs;
    e   = expQ.pop_front();
    obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, state_o};
    testCount++;
    assert (obs === e.vec) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %b expected %b", e.tag, obs, e.vec);
    end
  endtask

  // Drive right after a falling edge, check mid-low-phase, then advance one cycle.
  task automatic step(input string tag, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mr, input logic mc,
                      input logic br, input logic [5:0] expVec);
    applyStimulus(tag, rs1, rs2, rd, mr, mc, br, expVec);
    #2;
    checkOutput();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    step("reset", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RST_OUT);
    rst_n = 1'b1;

    step("run_idle",    5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, RUN_OUT);
    step("lu_rs2",      5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, STALL0);
    step("lu_after",    5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, RUN_OUT);
    step("lu_rd0",      5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, RUN_OUT);
    step("no_load",     5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0, RUN_OUT);
    step("lu_rs1",      5'd9, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0, STALL0);

    step("mc_c0",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, STALL0);
    step("mc_c1",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    step("mc_c2",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    step("mc_c3",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    step("mc_c4_rel",   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, REL_OUT);
    step("mc_c5_run",   5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, RUN_OUT);

    step("br_mc_c0",    5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, STALL0);
    step("br_mc_c1",    5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    step("br_in_wait",  5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1, 6'b1111_01);
    step("br_after",    5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, RUN_OUT);

    step("lu_and_br",   5'd4, 5'd2, 5'd4, 1'b1, 1'b0, 1'b1, 6'b1111_00);
    step("lu_and_mc",   5'd4, 5'd2, 5'd4, 1'b1, 1'b1, 1'b0, STALL0);
    step("lu_mc_after", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, RUN_OUT);

    step("rl_c0",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, STALL0);
    step("rl_c1",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    step("rl_c2",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    step("rl_c3",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    step("rel_lu",      5'd6, 5'd2, 5'd6, 1'b1, 1'b1, 1'b0, 6'b0001_10);
    step("rel_lu_after",5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, RUN_OUT);

    step("rs_c0",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, STALL0);
    step("rs_c1",       5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);
    // Reset asserted between edges while the wait is in progress.
    applyStimulus("rst_mid_wait", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, RST_OUT);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput();
`ifdef HAZARD_PERF_EN
    testCount++;
    assert ({perf_stall_cnt, perf_flush_cnt} === 32'd0) else begin
      failCount++;
      $error("[TB] FAIL perf_reset: observed %h/%h expected 0000/0000", perf_stall_cnt, perf_flush_cnt);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_idle", 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, RUN_OUT);
    step("post_rst_mc",   5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, STALL0);
    step("post_rst_wait", 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0, WAIT_ST);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
